// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - arb_state_e     : arbiter FSM states (IDLE, IF_WAIT, DM_WAIT)
//   - DATA_W          : address/data bus width
//   - CNT_W           : width of the wait (timeout) counter
//   - TIMEOUT_DEFAULT : default number of WAIT cycles before an access aborts
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } arb_state_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch port, data port and shared-memory port of the arbiter.
// Signal suffixes are written from the arbiter's point of view.
//   modport slave  : the arbiter (serves fetch/data requests, drives memory)
//   modport master : the environment (pipeline requesters + memory model)
// Fetch : if_req_i, if_addr_i -> if_data_o, if_ack_o
// Data  : dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i -> dm_rdata_o, dm_ack_o
// Memory: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i, mem_ack_i
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              if_req_i;
    logic [DATA_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [DATA_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_rdata_i, mem_ack_i,
        output if_data_o, if_ack_o,
        output dm_rdata_o, dm_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_rdata_i, mem_ack_i,
        input  if_data_o, if_ack_o,
        input  dm_rdata_o, dm_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arbiter_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_arbiter_wait_timer
// Counts WAIT cycles that passed without a memory acknowledge.
//   clk_i     : clock
//   rst_i     : synchronous active-low reset
//   clear_i   : restart the count (held while the arbiter is idle)
//   enable_i  : this is a WAIT cycle without mem_ack_i
//   limit_i   : number of unacknowledged WAIT cycles allowed (1..255)
//   expired_o : the current WAIT cycle is the limit_i-th one without ack
// ---------------------------------------------------------------------------
module mem_arbiter_wait_timer
    import mem_arbiter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority, saturate at the top of the range.
    always_comb begin
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of earlier unacknowledged WAIT cycles, so the
    // limit is reached in the cycle where count_q is one below it.
    assign expired_o = enable_i && (count_q == (limit_i - 8'd1));

endmodule : mem_arbiter_wait_timer

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between the instruction fetch port and the
// data (load/store) port of a pipeline. One transaction outstanding at a time;
// data accesses win over fetches when both request in the same idle cycle.
// An access with no memory acknowledge within TIMEOUT WAIT cycles is aborted,
// completed towards the requester with zero data, and flags err_o (sticky).
//   clk_i   : clock, all state on the rising edge
//   rst_i   : synchronous active-low reset
//   bus     : fetch / data / memory ports (mem_arbiter_if.slave)
//   stall_o : combinational pipeline stall while any request is unserved
//   err_o   : sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus,
    output logic         stall_o,
    output logic         err_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    arb_state_e        state_q,    state_d;
    logic [DATA_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              mem_req_q,  mem_req_d;
    logic              if_ack_q,   if_ack_d;
    logic              dm_ack_q,   dm_ack_d;
    logic [DATA_W-1:0] if_data_q,  if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              err_q,      err_d;

    logic if_req_s;
    logic dm_req_s;
    logic timer_clr_s;
    logic timer_en_s;
    logic timer_exp_s;

    // A requester whose ack is on the bus this cycle is still holding its
    // request; masking it prevents a duplicate grant of the finished access.
    assign if_req_s = bus.if_req_i && !if_ack_q;
    assign dm_req_s = bus.dm_req_i && !dm_ack_q;

    assign timer_clr_s = (state_q == IDLE);
    assign timer_en_s  = (state_q != IDLE) && !bus.mem_ack_i;

    mem_arbiter_wait_timer u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clr_s),
        .enable_i  (timer_en_s),
        .limit_i   (LIMIT),
        .expired_o (timer_exp_s)
    );

    // Next-state and registered-output logic of the arbiter FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        mem_req_d  = mem_req_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (dm_req_s) begin
                    state_d   = DM_WAIT;
                    addr_d    = bus.dm_addr_i;
                    we_d      = bus.dm_we_i;
                    wdata_d   = bus.dm_wdata_i;
                    mem_req_d = 1'b1;
                end else if (if_req_s) begin
                    state_d   = IF_WAIT;
                    addr_d    = bus.if_addr_i;
                    we_d      = 1'b0;
                    wdata_d   = 32'h0000_0000;
                    mem_req_d = 1'b1;
                end else begin
                    // mem_ack_i arriving here belongs to no access: ignored.
                    mem_req_d = 1'b0;
                end
            end

            IF_WAIT: begin
                // A real acknowledge wins over an expiry in the same cycle.
                if (bus.mem_ack_i) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if_data_d = bus.mem_rdata_i;
                    if_ack_d  = 1'b1;
                end else if (timer_exp_s) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if_data_d = 32'h0000_0000;
                    if_ack_d  = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            DM_WAIT: begin
                if (bus.mem_ack_i) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = bus.mem_rdata_i;
                    dm_ack_d   = 1'b1;
                end else if (timer_exp_s) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = 32'h0000_0000;
                    dm_ack_d   = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any outstanding access silently.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            addr_q     <= 32'h0000_0000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            mem_req_q  <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_data_q  <= 32'h0000_0000;
            dm_rdata_q <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            mem_req_q  <= mem_req_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign err_o           = err_q;

    // Stall must react in the same cycle a request appears.
    assign stall_o = (bus.if_req_i && !if_ack_q) || (bus.dm_req_i && !dm_ack_q);

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed stimulus with hand-computed expectations. Stimulus pushes expected
// requester completions (data + absolute cycle) and expected memory
// transactions into queues; monitor processes pop and compare whenever the
// DUT presents an ack or starts a memory request.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_i;
    logic stall_o;
    logic err_o;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .bus     (bus),
        .stall_o (stall_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ack_t        exp_if_q [$];
    ack_t        exp_dm_q [$];
    txn_t        exp_txn_q[$];
    logic [31:0] mem_data_q[$];

    bit          mem_auto  = 1'b1;
    int          mem_lat   = 0;
    logic        man_ack   = 1'b0;
    logic [31:0] man_rdata = 32'h0;

    int idx;
    int n;
    bit got_ack;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_if(input logic [31:0] d, input int c);
        ack_t a;
        a.data = d; a.cyc = c;
        exp_if_q.push_back(a);
    endtask

    task automatic push_dm(input logic [31:0] d, input int c);
        ack_t a;
        a.data = d; a.cyc = c;
        exp_dm_q.push_back(a);
    endtask

    task automatic push_txn(input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.addr = a; t.we = w; t.wdata = d;
        exp_txn_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Keep both requests high until their ack is seen, then drop them.
    task automatic service(input int budget);
        int k;
        bit gi, gd;
        k = 0;
        while ((bus.if_req_i || bus.dm_req_i) && k < budget) begin
            @(negedge clk);
            gi = bus.if_ack_o;
            gd = bus.dm_ack_o;
            tick();
            if (gi) bus.if_req_i = 1'b0;
            if (gd) bus.dm_req_i = 1'b0;
            k++;
        end
        if (bus.if_req_i || bus.dm_req_i) begin
            check1("service_timeout_req_pending", 1'b1, 1'b0);
            bus.if_req_i = 1'b0;
            bus.dm_req_i = 1'b0;
        end
    endtask

    // Memory model + transaction monitor (sole driver of mem_ack_i/mem_rdata_i).
    initial begin : responder
        bit   prev_req;
        int   wait_cnt;
        bit   have_cur;
        txn_t cur;
        prev_req = 1'b0; wait_cnt = 0; have_cur = 1'b0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_o && !prev_req) begin
                wait_cnt = 0;
                if (exp_txn_q.size() == 0) begin
                    check1("txn_unexpected_mem_req", 1'b1, 1'b0);
                    have_cur = 1'b0;
                end else begin
                    cur = exp_txn_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (bus.mem_req_o && have_cur) begin
                check32("txn_addr", bus.mem_addr_o, cur.addr);
                check1("txn_we", bus.mem_we_o, cur.we);
                if (cur.we) check32("txn_wdata", bus.mem_wdata_o, cur.wdata);
            end
            if (mem_auto) begin
                if (bus.mem_req_o && wait_cnt == mem_lat) begin
                    bus.mem_ack_i = 1'b1;
                    if (mem_data_q.size() == 0) begin
                        check1("mem_data_queue_empty", 1'b1, 1'b0);
                        bus.mem_rdata_i = 32'h0;
                    end else begin
                        bus.mem_rdata_i = mem_data_q.pop_front();
                    end
                end else begin
                    bus.mem_ack_i = 1'b0;
                    if (bus.mem_req_o) wait_cnt++;
                end
            end else begin
                bus.mem_ack_i   = man_ack;
                bus.mem_rdata_i = man_rdata;
            end
            prev_req = bus.mem_req_o;
        end
    end

    // Completion scoreboard and stall monitor.
    initial begin : ack_monitor
        bit   prev_if, prev_dm;
        ack_t e;
        logic exp_stall;
        prev_if = 1'b0; prev_dm = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.if_ack_o) begin
                check1("if_ack_single_pulse", prev_if, 1'b0);
                if (exp_if_q.size() == 0) begin
                    check1("if_ack_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_if_q.pop_front();
                    check32("if_data", bus.if_data_o, e.data);
                    check32("if_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bus.dm_ack_o) begin
                check1("dm_ack_single_pulse", prev_dm, 1'b0);
                if (exp_dm_q.size() == 0) begin
                    check1("dm_ack_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_dm_q.pop_front();
                    check32("dm_rdata", bus.dm_rdata_o, e.data);
                    check32("dm_ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            exp_stall = (bus.if_req_i && !bus.if_ack_o) || (bus.dm_req_i && !bus.dm_ack_o);
            check1("stall", stall_o, exp_stall);
            prev_if = bus.if_ack_o;
            prev_dm = bus.dm_ack_o;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst_i          = 1'b0;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'h0;
        bus.dm_req_i   = 1'b0;
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = 32'h0;
        bus.dm_wdata_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1 ("rst_if_ack",   bus.if_ack_o,    1'b0);
        check1 ("rst_dm_ack",   bus.dm_ack_o,    1'b0);
        check32("rst_if_data",  bus.if_data_o,   32'h0);
        check32("rst_dm_rdata", bus.dm_rdata_o,  32'h0);
        check1 ("rst_mem_req",  bus.mem_req_o,   1'b0);
        check1 ("rst_mem_we",   bus.mem_we_o,    1'b0);
        check32("rst_mem_addr", bus.mem_addr_o,  32'h0);
        check32("rst_mem_wdata",bus.mem_wdata_o, 32'h0);
        check1 ("rst_err",      err_o,           1'b0);
        tick();
        rst_i = 1'b1;
        tick();

        // Single fetch, memory acks 2 cycles after mem_req_o: if_ack_o at cycle 4
        mem_auto = 1'b1; mem_lat = 2;
        mem_data_q.push_back(32'h8C22_0004);
        push_txn(32'h0000_0010, 1'b0, 32'h0);
        push_if(32'h8C22_0004, cyc + 4);
        bus.if_addr_i = 32'h0000_0010;
        bus.if_req_i  = 1'b1;
        service(30);
        tick();

        // Simultaneous fetch and load: load first, fetch granted in dm_ack cycle
        mem_lat = 1;
        mem_data_q.push_back(32'h1111_2222);
        mem_data_q.push_back(32'h3333_4444);
        push_txn(32'h0000_0020, 1'b0, 32'h0);
        push_txn(32'h0000_0100, 1'b0, 32'h0);
        push_dm(32'h1111_2222, cyc + 3);
        push_if(32'h3333_4444, cyc + 6);
        bus.dm_we_i    = 1'b0;
        bus.dm_addr_i  = 32'h0000_0020;
        bus.dm_wdata_i = 32'h0;
        bus.if_addr_i  = 32'h0000_0100;
        bus.dm_req_i   = 1'b1;
        bus.if_req_i   = 1'b1;
        service(40);
        tick();

        // Store: attributes held for every WAIT cycle until mem_ack_i
        mem_lat = 3;
        mem_data_q.push_back(32'h0BAD_F00D);
        push_txn(32'h0000_0040, 1'b1, 32'hDEAD_BEEF);
        push_dm(32'h0BAD_F00D, cyc + 5);
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h0000_0040;
        bus.dm_wdata_i = 32'hDEAD_BEEF;
        bus.dm_req_i   = 1'b1;
        service(30);
        bus.dm_we_i = 1'b0;
        tick();

        // Back-to-back fetches, 1-cycle memory: one access every 3 cycles
        mem_lat = 0;
        for (int i = 0; i < 3; i++) begin
            mem_data_q.push_back(32'hA000_0001 + 32'(i));
            push_txn(32'h0000_0200 + 32'(4 * i), 1'b0, 32'h0);
            push_if(32'hA000_0001 + 32'(i), cyc + 2 + 3 * i);
        end
        bus.if_addr_i = 32'h0000_0200;
        bus.if_req_i  = 1'b1;
        idx = 0; n = 0;
        while (bus.if_req_i && n < 60) begin
            @(negedge clk);
            got_ack = bus.if_ack_o;
            tick();
            if (got_ack) begin
                idx++;
                if (idx < 3) bus.if_addr_i = 32'h0000_0200 + 32'(4 * idx);
                else         bus.if_req_i  = 1'b0;
            end
            n++;
        end
        if (bus.if_req_i) begin
            check1("b2b_timeout_req_pending", 1'b1, 1'b0);
            bus.if_req_i = 1'b0;
        end
        tick();

        // Stray mem_ack_i while idle is ignored; data outputs hold
        mem_auto  = 1'b0;
        man_rdata = 32'hFFFF_FFFF;
        man_ack   = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check32("hold_if_data",  bus.if_data_o,  32'hA000_0003);
        check32("hold_dm_rdata", bus.dm_rdata_o, 32'h0BAD_F00D);
        check1 ("idle_mem_req",  bus.mem_req_o,  1'b0);
        tick();

        // mem_ack_i on the timeout cycle (15th WAIT cycle) is a normal completion
        push_txn(32'h0000_0084, 1'b0, 32'h0);
        push_dm(32'h5A5A_A5A5, cyc + 16);
        bus.dm_addr_i = 32'h0000_0084;
        bus.dm_req_i  = 1'b1;
        repeat (15) tick();
        man_rdata = 32'h5A5A_A5A5;
        man_ack   = 1'b1;
        tick();
        man_ack = 1'b0;
        @(negedge clk);
        check1("edge_ack_no_err", err_o, 1'b0);
        check1("edge_ack_req_low", bus.mem_req_o, 1'b0);
        tick();
        bus.dm_req_i = 1'b0;
        tick();

        // No memory ack: abort after 15 WAIT cycles, zero data, sticky error
        push_txn(32'h0000_0080, 1'b0, 32'h0);
        push_dm(32'h0000_0000, cyc + 16);
        bus.dm_addr_i = 32'h0000_0080;
        bus.dm_req_i  = 1'b1;
        repeat (15) tick();
        @(negedge clk);
        check1("to_req_cycle15", bus.mem_req_o, 1'b1);
        check1("to_err_cycle15", err_o, 1'b0);
        tick();
        @(negedge clk);
        check1("to_req_cycle16", bus.mem_req_o, 1'b0);
        check1("to_err_cycle16", err_o, 1'b1);
        tick();
        bus.dm_req_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check1("to_err_sticky", err_o, 1'b1);
        tick();

        // A successful access afterwards leaves err_o set
        mem_auto = 1'b1; mem_lat = 0;
        mem_data_q.push_back(32'h0000_1234);
        push_txn(32'h0000_0300, 1'b0, 32'h0);
        push_if(32'h0000_1234, cyc + 2);
        bus.if_addr_i = 32'h0000_0300;
        bus.if_req_i  = 1'b1;
        service(20);
        @(negedge clk);
        check1("err_sticky_after_ok", err_o, 1'b1);
        tick();

        // Reset in DM_WAIT, then a late mem_ack_i: no dm_ack_o, memory idle
        mem_auto = 1'b0; man_ack = 1'b0;
        push_txn(32'h0000_0044, 1'b1, 32'hCAFE_0001);
        bus.dm_we_i    = 1'b1;
        bus.dm_addr_i  = 32'h0000_0044;
        bus.dm_wdata_i = 32'hCAFE_0001;
        bus.dm_req_i   = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check1("rw_req_before_rst", bus.mem_req_o, 1'b1);
        tick();
        rst_i        = 1'b0;
        bus.dm_req_i = 1'b0;
        bus.dm_we_i  = 1'b0;
        tick();
        rst_i = 1'b1;
        @(negedge clk);
        check1 ("rw_req_after_rst",  bus.mem_req_o,  1'b0);
        check1 ("rw_err_cleared",    err_o,          1'b0);
        check1 ("rw_dm_ack",         bus.dm_ack_o,   1'b0);
        check32("rw_dm_rdata",       bus.dm_rdata_o, 32'h0);
        check32("rw_if_data",        bus.if_data_o,  32'h0);
        check32("rw_mem_addr",       bus.mem_addr_o, 32'h0);
        tick();
        man_rdata = 32'h7777_7777;
        man_ack   = 1'b1;
        tick();
        man_ack = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check1("rw_req_after_late_ack", bus.mem_req_o, 1'b0);
        check1("rw_no_dm_ack_late",     bus.dm_ack_o,  1'b0);
        tick();

        // Every expectation must have been consumed
        check32("left_if_acks",  32'(exp_if_q.size()),   32'h0);
        check32("left_dm_acks",  32'(exp_dm_q.size()),   32'h0);
        check32("left_txns",     32'(exp_txn_q.size()),  32'h0);
        check32("left_mem_data", 32'(mem_data_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles an access waits for mem_ack_i before abort (legal range 1..255).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 if_req_i  input  1  instruction-fetch read request; held high until if_ack_o.
REQ-005 if_addr_i  input  32  fetch byte address (PC).
REQ-006 if_data_o  output  32  fetched instruction, valid while if_ack_o high.
REQ-007 if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-008 dm_req_i  input  1  data-access request (MEM-stage MemRead or MemWrite); held high until dm_ack_o.
REQ-009 dm_we_i  input  1  1 = store, 0 = load.
REQ-010 dm_addr_i  input  32  data byte address (EX/MEM ALU result).
REQ-011 dm_wdata_i  input  32  store data.
REQ-012 dm_rdata_o  output  32  load data, valid while dm_ack_o high.
REQ-013 dm_ack_o  output  1  one-cycle data completion pulse.
REQ-014 mem_req_o  output  1  request to shared single-port memory.
REQ-015 mem_we_o, mem_addr_o (32), mem_wdata_o (32)  output  transaction attributes, stable while mem_req_o high.
REQ-016 mem_rdata_i  input  32  memory read data, valid with mem_ack_i.
REQ-017 mem_ack_i  input  1  one-cycle memory completion pulse.
REQ-018 stall_o  output  1  pipeline stall to PC and IF/ID Stall_i.
REQ-019 err_o  output  1  sticky timeout flag.

Function
REQ-020 FSM states IDLE, IF_WAIT, DM_WAIT; exactly one transaction outstanding.
REQ-021 IDLE: dm_req_i has priority over if_req_i (older instruction first); winner's address, we, wdata latched at grant; next state DM_WAIT or IF_WAIT.
REQ-022 mem_req_o SHALL be high in every WAIT-state cycle, driven from latched registers; fetch grants drive mem_we_o = 0.
REQ-023 In WAIT on mem_ack_i: mem_rdata_i registered to granted requester's data output, requester's ack pulsed high next cycle for exactly one cycle, next state IDLE.
REQ-024 Latency: req seen in IDLE at cycle 0, mem_req_o from cycle 1, mem_ack_i at cycle k (k >= 1), ack_o at cycle k+1.
REQ-025 During the cycle a requester's ack_o is high, that requester's req_i SHALL be ignored for arbitration; other requester may be granted that cycle.
REQ-026 stall_o = (if_req_i AND NOT if_ack_o) OR (dm_req_i AND NOT dm_ack_o), combinational.
REQ-027 Wait counter (8 bits) clears at grant, increments each WAIT cycle without mem_ack_i; on reaching TIMEOUT: mem_req_o drops, requester acked with data 0x00000000, err_o set, next state IDLE.
REQ-028 mem_ack_i in IDLE SHALL be ignored; mem_ack_i on the timeout cycle SHALL be honoured as normal completion (no error).
REQ-029 Request inputs changing during WAIT SHALL not affect the outstanding transaction.
REQ-030 if_data_o/dm_rdata_o SHALL hold their last value when ack low.

Reset
REQ-031 rst_i low at a clock edge: state IDLE, counter 0, all outputs except stall_o 0, err_o cleared, outstanding transaction discarded without ack.
REQ-032 Reset mid-WAIT: mem_req_o low the cycle after the reset edge; late mem_ack_i ignored.

Structure
REQ-033 Shared package holds state enum (IDLE, IF_WAIT, DM_WAIT), TIMEOUT default, 32-bit width constant.
REQ-034 One sub-module wait_timer (clear, enable, limit -> expired) is natural; remainder flat.

Verification
REQ-035 Fetch only, addr 0x0000_0010, memory acks 2 cycles after mem_req_o with 0x8C22_0004 -> if_ack_o at cycle 4, if_data_o = 0x8C22_0004, stall_o high cycles 0-3.
REQ-036 if_req_i and dm_req_i (load, addr 0x20) same cycle -> data granted first, dm_ack_o then fetch granted the ack cycle, if_ack_o after second mem_ack_i.
REQ-037 Store addr 0x40 data 0xDEAD_BEEF -> mem_we_o = 1, mem_wdata_o = 0xDEAD_BEEF held until mem_ack_i, dm_ack_o one cycle.
REQ-038 No mem_ack_i, TIMEOUT = 15 -> mem_req_o drops after 15 WAIT cycles, ack with data 0, err_o stays 1 until rst_i low.
REQ-039 rst_i low during DM_WAIT, then mem_ack_i -> no dm_ack_o, state IDLE, mem_req_o low.
REQ-040 Back-to-back fetches with 1-cycle memory -> one access per 3 cycles, no duplicate grant from held if_req_i.
